div_iterative: RTL and testbench

//  Multi-cycle RV32M divider for DIV/DIVU/REM/REMU. It runs a radix-2 restoring

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sign_fix.sv | 12 +
 rtl/div_iterative.sv | 149 ++++++++++++++
 tb/tb_div_iterative.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings and sizing for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned DIV_XLEN   = 32;
  localparam int unsigned ITER_COUNT = DIV_XLEN;
  localparam int unsigned CNT_W      = $clog2(DIV_XLEN);

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and result sign restore.
module div_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/div_iterative.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, borrowing the core's shared add/sub unit.
module div_iterative
  import div_pkg::*;
#(
  parameter int unsigned XLEN      = DIV_XLEN,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_sub,
  input  logic [XLEN-1:0] add_out
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            freeze_q, freeze_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            is_signed, dvd_neg, dvs_neg;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] dvd_abs, dvs_abs, quo_fixed, rem_fixed;
  logic [XLEN-1:0] shift_s;
  logic            msb_out, borrow;

  assign is_signed = ~op[0];
  assign dvd_neg   = is_signed & dividend[XLEN-1];
  assign dvs_neg   = is_signed & divisor[XLEN-1];
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign special   = div_zero | ovf;

  div_sign_fix #(.W(XLEN)) u_abs_dvd (.din(dividend), .neg(dvd_neg),   .dout(dvd_abs));
  div_sign_fix #(.W(XLEN)) u_abs_dvs (.din(divisor),  .neg(dvs_neg),   .dout(dvs_abs));
  div_sign_fix #(.W(XLEN)) u_fix_quo (.din(q_q),      .neg(quo_neg_q), .dout(quo_fixed));
  div_sign_fix #(.W(XLEN)) u_fix_rem (.din(r_q),      .neg(rem_neg_q), .dout(rem_fixed));

  assign shift_s = {r_q[XLEN-2:0], q_q[XLEN-1]};
  assign msb_out = r_q[XLEN-1];
  // Borrow of the 33-bit compare {msb_out,S} - D, recovered from the 32-bit adder result.
  assign borrow  = ~msb_out & ((~shift_s[XLEN-1] & d_q[XLEN-1]) |
                               (~(shift_s[XLEN-1] ^ d_q[XLEN-1]) & add_out[XLEN-1]));

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    freeze_d  = freeze_q;
    result_d  = result_q;
    done_d    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ITER;
          op_d      = op;
          quo_neg_d = (dvd_neg ^ dvs_neg) & ~div_zero;
          rem_neg_d = dvd_neg;
          r_d       = '0;
          q_d       = dvd_abs;
          d_d       = dvs_abs;
          cnt_d     = CNT_W'(ITER_COUNT - 1);
          freeze_d  = 1'b0;
          // Early-out preloads the final Q/R and spends one frozen ITER cycle, giving a 2-edge latency.
          if ((EARLY_OUT != 0) && special) begin
            freeze_d  = 1'b1;
            cnt_d     = '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            q_d       = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            r_d       = div_zero ? dividend : '0;
          end
        end
      end
      S_ITER: begin
        if (!freeze_q) begin
          add_a   = shift_s;
          add_b   = d_q;
          add_sub = 1'b1;
          r_d     = borrow ? shift_s : add_out;
          q_d     = {q_q[XLEN-2:0], ~borrow};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = op_q[1] ? rem_fixed : quo_fixed;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      freeze_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      freeze_q  <= freeze_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_iterative.sv
// Directed bench for div_iterative with an exact 32-bit subtract model of the shared adder.
module tb_div_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result, add_a, add_b, add_out;
  logic        add_sub;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign add_out = add_sub ? (add_a - add_b) : (add_a + add_b);

  div_iterative #(.XLEN(32), .EARLY_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_out(add_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one op, count edges until done (bounded), check latency and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    if (!done) n = 99;
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result, exp);
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  initial begin
    int ndone, at;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_sub", {31'd0, add_sub}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
    run_op("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
    run_op("divu_dz",    2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_dz",    2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 2);
    run_op("div_dz",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem_dz_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    run_op("divu_big_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("divu_nosig", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("remu_nosig", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("divu_3_10",  2'b01, 32'd3, 32'd10, 32'd0, 33);
    run_op("remu_3_10",  2'b11, 32'd3, 32'd10, 32'd3, 33);
    run_op("divu_msb",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
    run_op("remu_msb",   2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);

    // start held high throughout the operation must not disturb it
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    op = 2'b11; dividend = 32'd5; divisor = 32'd1;
    ndone = 0; at = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (i == 10) check("hold_busy", {31'd0, busy}, 32'd1);
      if (done) begin ndone++; at = i; end
    end
    start = 1'b0;
    check("hold_ndone", ndone, 32'd1);
    check("hold_at", at, 32'd33);
    check("hold_res", result, 32'd14);
    @(posedge clk); #1;
    check("hold_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_add_sub", {31'd0, add_sub}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("mid_nodone", ndone, 32'd0);
    run_op("after_rst", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

    // a few random operands of each op against the reference function
    for (int k = 0; k < 32; k++) begin
      a = $urandom();
      b = (k % 4 == 0) ? $urandom_range(1, 20) : $urandom();
      if (k % 8 == 3) a = a | 32'h8000_0000;
      run_op("rand", 2'(k % 4), a, b, ref_div(2'(k % 4), a, b), 33);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
